// File: rtl/uart_cmd_pkg.sv
// Shared opcode constants and FSM state encoding for the UART command responder.
package uart_cmd_pkg;

    localparam logic [7:0] OPC_RF_WR    = 8'hAA;
    localparam logic [7:0] OPC_RF_RD    = 8'hBB;
    localparam logic [7:0] OPC_ALU_OPS  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOPS = 8'hDD;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        ALU_FUN,
        ALU_WAIT,
        TX_SEND,
        TX_HOLD
    } state_e;

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Link between the command FSM and the response byte sender.
interface uart_cmd_responder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    start;      // one-cycle request to send a response
    logic                    two_bytes;  // 1: send low then high byte, 0: low byte only
    logic [2*DATA_WIDTH-1:0] data;       // response payload, low byte goes out first
    logic                    done;       // one-cycle pulse once the last byte is out

    modport master (output start, two_bytes, data, input done);
    modport slave  (input start, two_bytes, data, output done);
endinterface

// File: rtl/cmd_tx_sender.sv
// Sends one or two response bytes to the UART transmitter, waiting for a full
// busy rise/fall handshake after every byte.
module cmd_tx_sender
    import uart_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                       i_CLK,
    input  logic                       i_RST,
    uart_cmd_responder_if.slave        tx_if,
    input  logic                       i_TX_busy,
    output logic [DATA_WIDTH-1:0]      o_TX_P_DATA,
    output logic                       o_TX_D_VLD
);

    state_e                  r_state, w_state;
    logic [2*DATA_WIDTH-1:0] r_buf, w_buf;
    logic                    r_more, w_more;
    logic                    r_seen, w_seen;
    logic [DATA_WIDTH-1:0]   r_txd, w_txd;
    logic                    r_vld, w_vld;
    logic                    r_done, w_done;

    assign o_TX_P_DATA = r_txd;
    assign o_TX_D_VLD  = r_vld;
    assign tx_if.done  = r_done;

    // Next-state: the data register only moves on a send, so it stays put through the hold.
    always_comb begin
        w_state = r_state;
        w_buf   = r_buf;
        w_more  = r_more;
        w_seen  = r_seen;
        w_txd   = r_txd;
        w_vld   = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            TX_SEND: begin
                if (!i_TX_busy) begin
                    w_txd   = r_buf[DATA_WIDTH-1:0];
                    w_vld   = 1'b1;
                    w_seen  = 1'b0;
                    w_state = TX_HOLD;
                end
            end
            TX_HOLD: begin
                if (i_TX_busy) begin
                    w_seen = 1'b1;
                end else if (r_seen) begin
                    if (r_more) begin
                        w_buf   = r_buf >> DATA_WIDTH;
                        w_more  = 1'b0;
                        w_state = TX_SEND;
                    end else begin
                        w_done  = 1'b1;
                        w_state = IDLE;
                    end
                end
            end
            default: begin
                if (tx_if.start) begin
                    w_buf   = tx_if.data;
                    w_more  = tx_if.two_bytes;
                    w_state = TX_SEND;
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_state <= IDLE;
            r_buf   <= '0;
            r_more  <= 1'b0;
            r_seen  <= 1'b0;
            r_txd   <= '0;
            r_vld   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_buf   <= w_buf;
            r_more  <= w_more;
            r_seen  <= w_seen;
            r_txd   <= w_txd;
            r_vld   <= w_vld;
            r_done  <= w_done;
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Decodes UART command bytes into register-file accesses and ALU operations,
// and returns read data / ALU results over the UART transmitter.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic [DATA_WIDTH-1:0]   i_RX_P_DATA,
    input  logic                    i_RX_D_VLD,
    output logic [DATA_WIDTH-1:0]   o_TX_P_DATA,
    output logic                    o_TX_D_VLD,
    input  logic                    i_TX_busy,
    output logic [ADDR_WIDTH-1:0]   o_RF_Address,
    output logic                    o_RF_WrEn,
    output logic                    o_RF_RdEn,
    output logic [DATA_WIDTH-1:0]   o_RF_WrData,
    input  logic [DATA_WIDTH-1:0]   i_RF_RdData,
    input  logic                    i_RF_RdData_Valid,
    output logic [FUN_WIDTH-1:0]    o_ALU_FUN,
    output logic                    o_ALU_EN,
    output logic                    o_CLK_GATE_EN,
    input  logic [2*DATA_WIDTH-1:0] i_ALU_OUT,
    input  logic                    i_ALU_OUT_VLD,
    output logic                    o_cmd_error
);

    state_e                  r_state, w_state;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr;
    logic [DATA_WIDTH-1:0]   r_wrdata, w_wrdata;
    logic                    r_wren, w_wren;
    logic                    r_rden, w_rden;
    logic [FUN_WIDTH-1:0]    r_fun, w_fun;
    logic                    r_alu_en, w_alu_en;
    logic                    r_gate, w_gate;
    logic                    r_alu_go, w_alu_go;   // ALU_EN due next cycle (gate leads by one)
    logic                    r_err, w_err;
    logic [2*DATA_WIDTH-1:0] r_result, w_result;
    logic                    r_tx_start, w_tx_start;
    logic                    r_two, w_two;

    uart_cmd_responder_if #(.DATA_WIDTH(DATA_WIDTH)) w_tx_if ();

    assign w_tx_if.start     = r_tx_start;
    assign w_tx_if.two_bytes = r_two;
    assign w_tx_if.data      = r_result;

    assign o_RF_Address  = r_addr;
    assign o_RF_WrData   = r_wrdata;
    assign o_RF_WrEn     = r_wren;
    assign o_RF_RdEn     = r_rden;
    assign o_ALU_FUN     = r_fun;
    assign o_ALU_EN      = r_alu_en;
    assign o_CLK_GATE_EN = r_gate;
    assign o_cmd_error   = r_err;

    cmd_tx_sender #(.DATA_WIDTH(DATA_WIDTH)) u_tx (
        .i_CLK       (i_CLK),
        .i_RST       (i_RST),
        .tx_if       (w_tx_if.slave),
        .i_TX_busy   (i_TX_busy),
        .o_TX_P_DATA (o_TX_P_DATA),
        .o_TX_D_VLD  (o_TX_D_VLD)
    );

    // Command decode: RX bytes are only looked at in byte-collecting states, so
    // anything arriving while waiting on the RF/ALU or the transmitter is dropped.
    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_wrdata   = r_wrdata;
        w_wren     = 1'b0;
        w_rden     = 1'b0;
        w_fun      = r_fun;
        w_alu_en   = 1'b0;
        w_gate     = r_gate;
        w_alu_go   = 1'b0;
        w_err      = 1'b0;
        w_result   = r_result;
        w_tx_start = 1'b0;
        w_two      = r_two;
        case (r_state)
            IDLE: begin
                if (i_RX_D_VLD) begin
                    case (i_RX_P_DATA)
                        DATA_WIDTH'(OPC_RF_WR):    w_state = WR_ADDR;
                        DATA_WIDTH'(OPC_RF_RD):    w_state = RD_ADDR;
                        DATA_WIDTH'(OPC_ALU_OPS):  w_state = OP_A;
                        DATA_WIDTH'(OPC_ALU_NOPS): w_state = ALU_FUN;
                        default:                   w_err   = 1'b1;
                    endcase
                end
            end
            WR_ADDR: if (i_RX_D_VLD) begin
                w_addr  = i_RX_P_DATA[ADDR_WIDTH-1:0];
                w_state = WR_DATA;
            end
            WR_DATA: if (i_RX_D_VLD) begin
                w_wrdata = i_RX_P_DATA;
                w_wren   = 1'b1;
                w_state  = IDLE;
            end
            RD_ADDR: if (i_RX_D_VLD) begin
                w_addr  = i_RX_P_DATA[ADDR_WIDTH-1:0];
                w_rden  = 1'b1;
                w_state = RD_WAIT;
            end
            RD_WAIT: if (i_RF_RdData_Valid) begin
                w_result   = {{DATA_WIDTH{1'b0}}, i_RF_RdData};
                w_two      = 1'b0;
                w_tx_start = 1'b1;
                w_state    = TX_SEND;
            end
            OP_A: if (i_RX_D_VLD) begin
                w_addr   = '0;
                w_wrdata = i_RX_P_DATA;
                w_wren   = 1'b1;
                w_state  = OP_B;
            end
            OP_B: if (i_RX_D_VLD) begin
                w_addr   = ADDR_WIDTH'(1);
                w_wrdata = i_RX_P_DATA;
                w_wren   = 1'b1;
                w_state  = ALU_FUN;
            end
            ALU_FUN: if (i_RX_D_VLD) begin
                w_fun    = i_RX_P_DATA[FUN_WIDTH-1:0];
                w_gate   = 1'b1;
                w_alu_go = 1'b1;
                w_state  = ALU_WAIT;
            end
            ALU_WAIT: begin
                w_alu_en = r_alu_go;
                if (i_ALU_OUT_VLD) begin
                    w_result   = i_ALU_OUT;
                    w_gate     = 1'b0;
                    w_two      = 1'b1;
                    w_tx_start = 1'b1;
                    w_state    = TX_SEND;
                end
            end
            TX_SEND: if (w_tx_if.done) w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wrdata   <= '0;
            r_wren     <= 1'b0;
            r_rden     <= 1'b0;
            r_fun      <= '0;
            r_alu_en   <= 1'b0;
            r_gate     <= 1'b0;
            r_alu_go   <= 1'b0;
            r_err      <= 1'b0;
            r_result   <= '0;
            r_tx_start <= 1'b0;
            r_two      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_addr     <= w_addr;
            r_wrdata   <= w_wrdata;
            r_wren     <= w_wren;
            r_rden     <= w_rden;
            r_fun      <= w_fun;
            r_alu_en   <= w_alu_en;
            r_gate     <= w_gate;
            r_alu_go   <= w_alu_go;
            r_err      <= w_err;
            r_result   <= w_result;
            r_tx_start <= w_tx_start;
            r_two      <= w_two;
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench: command tasks push expected RF/ALU/TX/error events,
// a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_uart_cmd_responder;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]   rx_data = '0;
    logic            rx_vld = 1'b0;
    logic [DW-1:0]   tx_data;
    logic            tx_vld;
    logic            uart_busy = 1'b0;
    logic            force_busy = 1'b0;
    logic            tx_busy;
    logic [AW-1:0]   rf_addr;
    logic            rf_wren, rf_rden;
    logic [DW-1:0]   rf_wrdata;
    logic [DW-1:0]   rf_rddata = '0;
    logic            rf_rdvld = 1'b0;
    logic [FW-1:0]   alu_fun;
    logic            alu_en, gate_en;
    logic [2*DW-1:0] alu_out = '0;
    logic            alu_vld = 1'b0;
    logic            cmd_err;

    assign tx_busy = uart_busy | force_busy;

    uart_cmd_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) dut (
        .i_CLK(clk), .i_RST(rst_n),
        .i_RX_P_DATA(rx_data), .i_RX_D_VLD(rx_vld),
        .o_TX_P_DATA(tx_data), .o_TX_D_VLD(tx_vld), .i_TX_busy(tx_busy),
        .o_RF_Address(rf_addr), .o_RF_WrEn(rf_wren), .o_RF_RdEn(rf_rden),
        .o_RF_WrData(rf_wrdata), .i_RF_RdData(rf_rddata), .i_RF_RdData_Valid(rf_rdvld),
        .o_ALU_FUN(alu_fun), .o_ALU_EN(alu_en), .o_CLK_GATE_EN(gate_en),
        .i_ALU_OUT(alu_out), .i_ALU_OUT_VLD(alu_vld), .o_cmd_error(cmd_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] wr_q[$];   // {addr, data}
    logic [3:0]  rd_q[$];
    logic [7:0]  tx_q[$];
    logic [3:0]  alu_q[$];
    bit          err_q[$];

    logic [7:0] model_rf[16];   // what the RF should hold, from the command stream
    logic [7:0] env_rf[16];     // RF contents as actually written by the DUT
    bit  tx_act   = 1'b0;
    bit  alu_mute = 1'b0;
    int  rd_delay = 2;
    logic samp_busy = 1'b0, samp_gate = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected strobe, value 0x%0h", name, act);
    endtask

    // Reference ALU attached to the DUT: plain arithmetic on the two operands.
    function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f[1:0])
            2'd0:    return 16'(a) + 16'(b);
            2'd1:    return 16'(a) - 16'(b);
            2'd2:    return 16'(a) * 16'(b);
            default: return {a, b};
        endcase
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({tx_data, tx_vld, rf_addr, rf_wren, rf_rden, rf_wrdata,
                    alu_fun, alu_en, gate_en, cmd_err});
    endfunction

    // What the DUT saw at the last edge, for "busy was low" and "gate led EN" checks.
    always @(posedge clk) begin
        samp_busy = tx_busy;
        samp_gate = gate_en;
    end

    // Monitor: pop and compare on every output strobe.
    always @(negedge clk) begin
        if (rf_wren) begin
            if (wr_q.size() != 0) check("rf_write", 32'({rf_addr, rf_wrdata}), 32'(wr_q.pop_front()));
            else unexpected("rf_write", 32'({rf_addr, rf_wrdata}));
        end
        if (rf_rden) begin
            if (rd_q.size() != 0) check("rf_read_addr", 32'(rf_addr), 32'(rd_q.pop_front()));
            else unexpected("rf_read", 32'(rf_addr));
        end
        if (tx_vld) begin
            if (tx_q.size() != 0) check("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
            else unexpected("tx_byte", 32'(tx_data));
            check("tx_sent_while_busy", 32'(samp_busy), 32'd0);
        end
        if (alu_en) begin
            if (alu_q.size() != 0) check("alu_fun", 32'(alu_fun), 32'(alu_q.pop_front()));
            else unexpected("alu_en", 32'(alu_fun));
            check("gate_with_en", 32'(gate_en), 32'd1);
            check("gate_before_en", 32'(samp_gate), 32'd1);
        end
        if (cmd_err) begin
            if (err_q.size() != 0) void'(err_q.pop_front());
            else unexpected("cmd_error", 32'd1);
        end
    end

    // UART transmitter: busy rises 0-1 cycles after a send and lasts 2-6 cycles.
    initial begin
        logic [7:0] held;
        forever begin
            @(negedge clk);
            if (tx_vld) begin
                held   = tx_data;
                tx_act = 1'b1;
                repeat ($urandom_range(0, 1)) @(negedge clk);
                uart_busy = 1'b1;
                repeat ($urandom_range(2, 6)) @(negedge clk);
                check("tx_data_stable", 32'(tx_data), 32'(held));
                uart_busy = 1'b0;
                tx_act    = 1'b0;
            end
        end
    end

    // Register file: stores DUT writes, answers reads after rd_delay cycles.
    initial begin
        logic [3:0] a;
        foreach (env_rf[i]) env_rf[i] = '0;
        forever begin
            @(negedge clk);
            if (rf_wren) env_rf[rf_addr] = rf_wrdata;
            if (rf_rden) begin
                a = rf_addr;
                repeat (rd_delay) @(negedge clk);
                rf_rddata = env_rf[a];
                rf_rdvld  = 1'b1;
                @(negedge clk);
                rf_rdvld  = 1'b0;
                rf_rddata = 8'($urandom);
            end
        end
    end

    // ALU: computes from the operands the DUT wrote, answers 1-3 cycles after EN.
    initial begin
        logic [3:0] f;
        forever begin
            @(negedge clk);
            if (alu_en && !alu_mute) begin
                f = alu_fun;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                check("gate_held_in_wait", 32'(gate_en), 32'd1);
                alu_out = alu_ref(f, env_rf[0], env_rf[1]);
                alu_vld = 1'b1;
                @(negedge clk);
                alu_vld = 1'b0;
                alu_out = 16'($urandom);
                check("gate_dropped", 32'(gate_en), 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_vld  = 1'b1;
        @(negedge clk);
        rx_vld  = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_junk(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom));
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        wr_q.push_back({a[3:0], d});
        model_rf[a[3:0]] = d;
        send_byte(8'hAA); gap(); send_byte(a); gap(); send_byte(d);
    endtask

    task automatic do_read(input logic [7:0] a, input int junk);
        rd_q.push_back(a[3:0]);
        tx_q.push_back(model_rf[a[3:0]]);
        send_byte(8'hBB); gap(); send_byte(a);
        send_junk(junk);
    endtask

    task automatic do_alu(input bit with_ops, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] f, input int junk);
        logic [15:0] r;
        if (with_ops) begin
            wr_q.push_back({4'd0, x});
            wr_q.push_back({4'd1, y});
            model_rf[0] = x;
            model_rf[1] = y;
            send_byte(8'hCC); gap(); send_byte(x); gap(); send_byte(y); gap();
        end else begin
            send_byte(8'hDD); gap();
        end
        alu_q.push_back(f[3:0]);
        r = alu_ref(f[3:0], model_rf[0], model_rf[1]);
        tx_q.push_back(r[7:0]);
        tx_q.push_back(r[15:8]);
        send_byte(f);
        send_junk(junk);
    endtask

    task automatic do_bad(input logic [7:0] op);
        err_q.push_back(1'b1);
        send_byte(op);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((wr_q.size() + rd_q.size() + tx_q.size() + alu_q.size() + err_q.size() != 0
                || tx_act) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: timeout, %0d tx bytes still expected", tx_q.size());
        end
        repeat (5) @(posedge clk);
    endtask

    function automatic logic [7:0] bad_op();
        logic [7:0] op;
        do op = 8'($urandom);
        while (op == 8'hAA || op == 8'hBB || op == 8'hCC || op == 8'hDD);
        return op;
    endfunction

    initial begin
        foreach (model_rf[i]) model_rf[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;

        // Opcode on the first byte after release, then the directed scenarios.
        do_write(8'h05, 8'h3C);                 wait_idle();
        rd_delay = 2;
        do_read(8'h05, 0);                      wait_idle();
        do_alu(1'b1, 8'h12, 8'h34, 8'h00, 0);  wait_idle();
        do_bad(8'h77);                          wait_idle();
        do_write(8'h0A, 8'h99);                 wait_idle();

        // Transmitter busy for 20 cycles: response must wait, extra bytes dropped.
        force_busy = 1'b1;
        do_read(8'h0A, 2);
        repeat (20) @(negedge clk);
        check("tx_held_by_busy", 32'(tx_q.size()), 32'd1);
        force_busy = 1'b0;
        wait_idle();

        // Random command mix.
        repeat (60) begin
            rd_delay = int'($urandom_range(1, 3));
            case ($urandom_range(0, 4))
                0: do_write(8'($urandom), 8'($urandom));
                1: do_read(8'($urandom), int'($urandom_range(0, 2)));
                2: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
                3: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom), int'($urandom_range(0, 2)));
                default: do_bad(bad_op());
            endcase
            wait_idle();
        end

        // Asynchronous reset while waiting on the ALU.
        alu_mute = 1'b1;
        do_alu(1'b1, 8'h5A, 8'hC3, 8'h03, 0);
        repeat (5) @(negedge clk);
        check("gate_on_in_alu_wait", 32'(gate_en), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 32'd0);
        tx_q.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        alu_mute = 1'b0;
        do_write(8'h03, 8'hE7);                 wait_idle();
        do_read(8'h03, 0);                      wait_idle();

        check("scoreboard_drained",
              32'(wr_q.size() + rd_q.size() + tx_q.size() + alu_q.size() + err_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning UART byte and register width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning register-file address width.
REQ-003 SHALL have parameter FUN_WIDTH, default 4, meaning ALU function-code width.
REQ-004 SHALL have one clock: i_CLK  in  1  sole clock, rising edge.
REQ-005 SHALL have reset i_RST  in  1  asynchronous, active-low.
REQ-006 SHALL have i_RX_P_DATA  in  DATA_WIDTH  received byte; i_RX_D_VLD  in  1  one-cycle byte-valid pulse.
REQ-007 SHALL have o_TX_P_DATA  out  DATA_WIDTH  response byte; o_TX_D_VLD  out  1  one-cycle send pulse; i_TX_busy  in  1  transmitter busy, already synchronized to i_CLK.
REQ-008 SHALL have o_RF_Address  out  ADDR_WIDTH; o_RF_WrEn, o_RF_RdEn  out  1; o_RF_WrData  out  DATA_WIDTH; i_RF_RdData  in  DATA_WIDTH; i_RF_RdData_Valid  in  1.
REQ-009 SHALL have o_ALU_FUN  out  FUN_WIDTH; o_ALU_EN  out  1; o_CLK_GATE_EN  out  1; i_ALU_OUT  in  2*DATA_WIDTH; i_ALU_OUT_VLD  in  1.
REQ-010 SHALL have o_cmd_error  out  1  one-cycle pulse on unknown opcode.

Function
REQ-011 SHALL decode the first byte in IDLE as opcode: 0xAA RF write, 0xBB RF read, 0xCC ALU with operands, 0xDD ALU without operands.
REQ-012 SHALL use states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_SEND, TX_HOLD.
REQ-013 SHALL, for 0xAA: WR_ADDR captures address byte (low ADDR_WIDTH bits), WR_DATA captures data; cycle after data byte, o_RF_WrEn=1 one cycle with address/data; return to IDLE; no response.
REQ-014 SHALL, for 0xBB: cycle after address byte, o_RF_RdEn=1 one cycle; RD_WAIT captures i_RF_RdData on i_RF_RdData_Valid; send one response byte.
REQ-015 SHALL, for 0xCC: OP_A byte written to RF address 0, OP_B byte to address 1 (each one-cycle o_RF_WrEn, cycle after byte), then ALU_FUN; 0xDD goes directly to ALU_FUN.
REQ-016 SHALL, on function byte: o_ALU_FUN latched, o_CLK_GATE_EN=1 next cycle, o_ALU_EN=1 one cycle after that for one cycle; ALU_WAIT captures i_ALU_OUT on i_ALU_OUT_VLD; o_CLK_GATE_EN drops the following cycle.
REQ-017 SHALL send ALU result as two bytes, low byte first.
REQ-018 SHALL in TX_SEND, when i_TX_busy=0, drive o_TX_P_DATA and pulse o_TX_D_VLD one cycle, enter TX_HOLD; TX_HOLD waits for busy rise then fall before next byte or IDLE.
REQ-019 SHALL hold o_TX_P_DATA stable from the send pulse until leaving TX_HOLD.
REQ-020 SHALL drop RX bytes arriving in RD_WAIT, ALU_WAIT, TX_SEND, TX_HOLD, with no error.
REQ-021 SHALL on unknown opcode pulse o_cmd_error one cycle and stay in IDLE.
REQ-022 SHALL treat i_RF_RdData_Valid/i_ALU_OUT_VLD outside their wait states as ignored.
REQ-023 SHALL drive all outputs from registers.

Reset
REQ-024 SHALL on i_RST=0 immediately enter IDLE, all outputs 0, captured bytes 0, regardless of current state.
REQ-025 SHALL after reset release accept an opcode on the first i_RX_D_VLD.

Structure
REQ-026 SHALL place opcode constants and state enumeration in shared package uart_cmd_pkg.
REQ-027 SHALL implement TX_SEND/TX_HOLD byte sequencing as sub-module cmd_tx_sender.

Verification
REQ-028 Bytes AA,05,3C -> one-cycle o_RF_WrEn, addr 5, data 0x3C; no TX.
REQ-029 Bytes BB,05; RdData 0x3C valid 2 cycles later -> one o_TX_D_VLD with 0x3C after busy low.
REQ-030 Bytes CC,12,34,00; ALU_OUT 0x0046 -> RF writes 0x12@0, 0x34@1; gate then ALU_EN; TX 0x46 then 0x00.
REQ-031 Byte 0x77 -> o_cmd_error one pulse, state IDLE, next AA command works.
REQ-032 i_TX_busy held 1 for 20 cycles during read response -> no o_TX_D_VLD until busy low; extra RX bytes dropped.
REQ-033 i_RST low mid-ALU_WAIT -> all outputs 0 asynchronously, IDLE on release.
